// File: rtl/ebs_pkg.sv
// Shared types and constants for the dcache event-based sampling (EBS) unit.
// The sample struct here carries the default widths; the top builds its own from its parameters.
package ebs_pkg;

    localparam int unsigned EBS_MODE_W = 2;

    typedef enum logic [EBS_MODE_W-1:0] {
        EBS_OFF  = 2'd0,
        EBS_ALL  = 2'd1,
        EBS_ADDR = 2'd2,
        EBS_PC   = 2'd3
    } ebs_mode_e;

    localparam int unsigned EBS_PORT_W = 2;
    localparam int unsigned EBS_PC_W   = 64;
    localparam int unsigned EBS_ADDR_W = 56;
    localparam int unsigned EBS_TS_W   = 32;

    typedef struct packed {
        logic [EBS_PORT_W-1:0] port;
        logic [EBS_PC_W-1:0]   pc;
        logic [EBS_ADDR_W-1:0] paddr;
        logic [EBS_TS_W-1:0]   ts;
    } ebs_sample_t;

endpackage

// File: rtl/wt_dcache_ebs_sampler_if.sv
// Sample stream from the EBS unit to the CSR/perf consumer (valid/ready, head sample fields).
interface wt_dcache_ebs_sampler_if #(
    parameter int unsigned PortW     = 2,
    parameter int unsigned PcWidth   = 64,
    parameter int unsigned AddrWidth = 56,
    parameter int unsigned TsWidth   = 32
);
    logic                 valid;
    logic                 ready;
    logic [PortW-1:0]     port;
    logic [PcWidth-1:0]   pc;
    logic [AddrWidth-1:0] paddr;
    logic [TsWidth-1:0]   ts;

    modport master (
        output valid,
        output port,
        output pc,
        output paddr,
        output ts,
        input  ready
    );

    modport slave (
        input  valid,
        input  port,
        input  pc,
        input  paddr,
        input  ts,
        output ready
    );
endinterface

// File: rtl/ebs_sample_fifo.sv
// Sample FIFO for the EBS unit. A push while full is accepted only when a pop happens in the same cycle;
// the head is presented straight from the storage array and forced to zero while empty.
module ebs_sample_fifo
    import ebs_pkg::*;
#(
    parameter type         sample_t  = ebs_sample_t,
    parameter int unsigned FifoDepth = 8
)(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  sample_t                    data_i,
    input  logic                       pop_i,
    output sample_t                    data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(FifoDepth):0] occupancy_o
);
    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned OccW = PtrW + 1;

    sample_t         mem_q [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [OccW-1:0] count_q;
    logic            push_ok;
    logic            pop_ok;

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == OccW'(FifoDepth));
    assign pop_ok      = pop_i & ~empty_o;
    assign push_ok     = push_i & (~full_o | pop_ok);
    assign occupancy_o = count_q;
    assign data_o      = empty_o ? sample_t'('0) : mem_q[rd_ptr_q];

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + OccW'(1);
                2'b01:   count_q <= count_q - OccW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !clr_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end
endmodule

// File: rtl/wt_dcache_ebs_sampler.sv
// Event-based sampling of dcache misses: filters per-port misses, takes one sample every period_i
// eligible misses, buffers samples in a FIFO, and keeps raw per-port miss counts and the last-miss PC.
module wt_dcache_ebs_sampler
    import ebs_pkg::*;
#(
    parameter int unsigned NumPorts  = 4,
    parameter int unsigned PcWidth   = 64,
    parameter int unsigned AddrWidth = 56,
    parameter int unsigned CntWidth  = 32,
    parameter int unsigned TsWidth   = 32,
    parameter int unsigned FifoDepth = 8,
    parameter int unsigned IrqThresh = 4
)(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          clear_i,
    input  logic [EBS_MODE_W-1:0]         mode_i,
    input  logic [CntWidth-1:0]           period_i,
    input  logic [PcWidth-1:0]            filt_base_i,
    input  logic [PcWidth-1:0]            filt_mask_i,
    input  logic [NumPorts-1:0]           miss_vld_i,
    input  logic [NumPorts*PcWidth-1:0]   miss_pc_i,
    input  logic [NumPorts*AddrWidth-1:0] miss_paddr_i,
    wt_dcache_ebs_sampler_if.master       smpl,
    output logic [$clog2(FifoDepth):0]    occupancy_o,
    output logic                          irq_o,
    output logic [CntWidth-1:0]           drop_cnt_o,
    output logic [NumPorts*CntWidth-1:0]  miss_cnt_o,
    output logic [PcWidth-1:0]            last_pc_o
);
    localparam int unsigned PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned OccW  = $clog2(FifoDepth) + 1;

    typedef struct packed {
        logic [PortW-1:0]     port;
        logic [PcWidth-1:0]   pc;
        logic [AddrWidth-1:0] paddr;
        logic [TsWidth-1:0]   ts;
    } entry_t;

    logic [NumPorts-1:0]  miss_ev;
    logic [NumPorts-1:0]  elig;
    logic [PcWidth-1:0]   port_pc    [NumPorts];
    logic [AddrWidth-1:0] port_paddr [NumPorts];

    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [TsWidth-1:0]    ts_q;
    logic [CntWidth-1:0]   drop_cnt_q;
    logic [PcWidth-1:0]    last_pc_q, last_pc_d;
    logic [EBS_MODE_W-1:0] mode_q;
    logic [CntWidth-1:0]   period_q;
    logic                  cfg_seen_q;

    logic [CntWidth-1:0] period_eff;
    logic [CntWidth-1:0] elig_cnt;
    logic [CntWidth-1:0] excess;
    logic [PortW-1:0]    sel_port;
    logic                cfg_wr;
    logic                fire;
    logic                pop;
    logic                drop;
    logic                fifo_full;
    logic                fifo_empty;
    entry_t              push_entry;
    entry_t              head_entry;

    // Per-port filter and raw miss counter.
    for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
        logic [PcWidth-1:0]  paddr_ext;
        logic                hit;
        logic [CntWidth-1:0] miss_cnt_q;

        assign port_pc[gi]    = miss_pc_i[gi*PcWidth +: PcWidth];
        assign port_paddr[gi] = miss_paddr_i[gi*AddrWidth +: AddrWidth];
        assign paddr_ext      = PcWidth'(port_paddr[gi]);

        always_comb begin
            hit = 1'b0;
            case (ebs_mode_e'(mode_i))
                EBS_ALL:  hit = 1'b1;
                EBS_ADDR: hit = (((paddr_ext ^ filt_base_i) & filt_mask_i) == '0);
                EBS_PC:   hit = (((port_pc[gi] ^ filt_base_i) & filt_mask_i) == '0);
                default:  hit = 1'b0;
            endcase
        end

        assign miss_ev[gi] = enable_i & miss_vld_i[gi];
        assign elig[gi]    = miss_ev[gi] & hit;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                miss_cnt_q <= '0;
            end else if (clear_i) begin
                miss_cnt_q <= '0;
            end else if (miss_ev[gi]) begin
                miss_cnt_q <= miss_cnt_q + CntWidth'(1);
            end
        end

        assign miss_cnt_o[gi*CntWidth +: CntWidth] = miss_cnt_q;
    end

    // Popcount of eligible ports and pick of the cnt-th one in ascending index order.
    always_comb begin
        elig_cnt = '0;
        sel_port = '0;
        for (int k = 0; k < NumPorts; k++) begin
            if (elig[k]) begin
                elig_cnt = elig_cnt + CntWidth'(1);
                if (elig_cnt == cnt_q) begin
                    sel_port = PortW'(k);
                end
            end
        end
    end

    assign period_eff = (period_i == '0) ? CntWidth'(1) : period_i;
    // Config values present when reset is released are the baseline, not a write.
    assign cfg_wr     = cfg_seen_q & ((mode_i != mode_q) | (period_i != period_q));
    assign fire       = ~cfg_wr & (elig_cnt >= cnt_q);
    assign excess     = elig_cnt - cnt_q;

    always_comb begin
        cnt_d = cnt_q - elig_cnt;
        if (clear_i || cfg_wr) begin
            cnt_d = period_eff;
        end else if (fire) begin
            cnt_d = (excess >= period_eff) ? CntWidth'(1) : (period_eff - excess);
        end
    end

    always_comb begin
        last_pc_d = last_pc_q;
        for (int k = NumPorts - 1; k >= 0; k--) begin
            if (miss_ev[k]) begin
                last_pc_d = port_pc[k];
            end
        end
    end

    assign push_entry.port  = sel_port;
    assign push_entry.pc    = port_pc[sel_port];
    assign push_entry.paddr = port_paddr[sel_port];
    assign push_entry.ts    = ts_q;

    assign pop  = ~fifo_empty & smpl.ready;
    assign drop = fire & fifo_full & ~pop & ~clear_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= CntWidth'(1);
            ts_q       <= '0;
            drop_cnt_q <= '0;
            last_pc_q  <= '0;
            mode_q     <= '0;
            period_q   <= '0;
            cfg_seen_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ts_q       <= ts_q + TsWidth'(1);
            last_pc_q  <= last_pc_d;
            mode_q     <= mode_i;
            period_q   <= period_i;
            cfg_seen_q <= 1'b1;
            if (clear_i) begin
                drop_cnt_q <= '0;
            end else if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + CntWidth'(1);
            end
        end
    end

    ebs_sample_fifo #(
        .sample_t  (entry_t),
        .FifoDepth (FifoDepth)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (clear_i),
        .push_i      (fire),
        .data_i      (push_entry),
        .pop_i       (pop),
        .data_o      (head_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .occupancy_o (occupancy_o)
    );

    assign smpl.valid  = ~fifo_empty;
    assign smpl.port   = head_entry.port;
    assign smpl.pc     = head_entry.pc;
    assign smpl.paddr  = head_entry.paddr;
    assign smpl.ts     = head_entry.ts;

    assign irq_o       = (occupancy_o >= OccW'(IrqThresh));
    assign drop_cnt_o  = drop_cnt_q;
    assign last_pc_o   = last_pc_q;
endmodule

// File: tb/tb_wt_dcache_ebs_sampler.sv
// Directed bench for wt_dcache_ebs_sampler (4 ports, 4-entry FIFO, irq at 4 entries).
`timescale 1ns/1ps
module tb_wt_dcache_ebs_sampler;
    localparam int NP = 4;
    localparam int PCW = 64;
    localparam int AW = 56;
    localparam int CW = 32;
    localparam int TW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              clear = 1'b0;
    logic [1:0]        mode = '0;
    logic [CW-1:0]     period = '0;
    logic [PCW-1:0]    filt_base = '0;
    logic [PCW-1:0]    filt_mask = '0;
    logic [NP-1:0]     miss_vld = '0;
    logic [NP*PCW-1:0] miss_pc = '0;
    logic [NP*AW-1:0]  miss_paddr = '0;
    logic [2:0]        occupancy;
    logic              irq;
    logic [CW-1:0]     drop_cnt;
    logic [NP*CW-1:0]  miss_cnt;
    logic [PCW-1:0]    last_pc;

    int n_cmp = 0;
    int n_fail = 0;

    wt_dcache_ebs_sampler_if #(.PortW(2), .PcWidth(PCW), .AddrWidth(AW), .TsWidth(TW)) smpl_if ();

    wt_dcache_ebs_sampler #(
        .NumPorts(NP), .PcWidth(PCW), .AddrWidth(AW), .CntWidth(CW),
        .TsWidth(TW), .FifoDepth(4), .IrqThresh(4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .clear_i      (clear),
        .mode_i       (mode),
        .period_i     (period),
        .filt_base_i  (filt_base),
        .filt_mask_i  (filt_mask),
        .miss_vld_i   (miss_vld),
        .miss_pc_i    (miss_pc),
        .miss_paddr_i (miss_paddr),
        .smpl         (smpl_if),
        .occupancy_o  (occupancy),
        .irq_o        (irq),
        .drop_cnt_o   (drop_cnt),
        .miss_cnt_o   (miss_cnt),
        .last_pc_o    (last_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] m, input logic [CW-1:0] per);
        #2;
        rst = 1'b1;
        mode = m;
        period = per;
        enable = 1'b1;
        clear = 1'b0;
        miss_vld = '0;
        smpl_if.ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic miss(input int port, input logic [PCW-1:0] pc, input logic [AW-1:0] pa);
        miss_vld = '0;
        miss_vld[port] = 1'b1;
        miss_pc[port*PCW +: PCW] = pc;
        miss_paddr[port*AW +: AW] = pa;
        tick();
        miss_vld = '0;
    endtask

    task automatic pop(output logic v, output logic [1:0] p, output logic [PCW-1:0] pc,
                       output logic [AW-1:0] pa, output logic [TW-1:0] ts);
        v = smpl_if.valid;
        p = smpl_if.port;
        pc = smpl_if.pc;
        pa = smpl_if.paddr;
        ts = smpl_if.ts;
        smpl_if.ready = 1'b1;
        tick();
        smpl_if.ready = 1'b0;
        $display("pop: valid=%0b port=%0d pc=%h paddr=%h ts=%0d", v, p, pc, pa, ts);
    endtask

    task automatic test_reset();
        do_reset(2'd1, 32'd1);
        n_cmp++; if (smpl_if.valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", smpl_if.valid); end
        n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rst_occ: got %0d exp 0", occupancy); end
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b exp 0", irq); end
        n_cmp++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL rst_drop: got %0d exp 0", drop_cnt); end
        n_cmp++; if (miss_cnt !== '0) begin n_fail++; $display("FAIL rst_misscnt: got %h exp 0", miss_cnt); end
        n_cmp++; if (last_pc !== '0) begin n_fail++; $display("FAIL rst_lastpc: got %h exp 0", last_pc); end
        n_cmp++; if (smpl_if.pc !== '0) begin n_fail++; $display("FAIL rst_smplpc: got %h exp 0", smpl_if.pc); end
    endtask

    task automatic test_period();
        logic v; logic [1:0] p; logic [PCW-1:0] pc; logic [AW-1:0] pa; logic [TW-1:0] ts; logic [TW-1:0] ts_prev;
        do_reset(2'd1, 32'd3);
        for (int i = 0; i < 7; i++) begin
            miss(1, 64'h1000 + 64'(i), 56'h2000 + 56'(i * 'h40));
        end
        n_cmp++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL per_occ: got %0d exp 3", occupancy); end
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL per_irq: got %b exp 0", irq); end
        n_cmp++; if (miss_cnt[1*CW +: CW] !== 32'd7) begin n_fail++; $display("FAIL per_misscnt1: got %0d exp 7", miss_cnt[1*CW +: CW]); end
        n_cmp++; if (last_pc !== 64'h1006) begin n_fail++; $display("FAIL per_lastpc: got %h exp 1006", last_pc); end
        ts_prev = '0;
        for (int k = 0; k < 3; k++) begin
            pop(v, p, pc, pa, ts);
            n_cmp++; if (v !== 1'b1) begin n_fail++; $display("FAIL per_valid%0d: got %b exp 1", k, v); end
            n_cmp++; if (p !== 2'd1) begin n_fail++; $display("FAIL per_port%0d: got %0d exp 1", k, p); end
            n_cmp++; if (pc !== 64'h1000 + 64'(3 * k)) begin n_fail++; $display("FAIL per_pc%0d: got %h exp %h", k, pc, 64'h1000 + 64'(3 * k)); end
            n_cmp++; if (pa !== 56'h2000 + 56'(k * 'hC0)) begin n_fail++; $display("FAIL per_paddr%0d: got %h exp %h", k, pa, 56'h2000 + 56'(k * 'hC0)); end
            if (k > 0) begin
                n_cmp++; if (ts - ts_prev !== 32'd3) begin n_fail++; $display("FAIL per_tsdelta%0d: got %0d exp 3", k, ts - ts_prev); end
            end
            ts_prev = ts;
        end
        n_cmp++; if (smpl_if.valid !== 1'b0) begin n_fail++; $display("FAIL per_drained: got %b exp 0", smpl_if.valid); end
    endtask

    task automatic test_multi_port();
        logic v; logic [1:0] p; logic [PCW-1:0] pc; logic [AW-1:0] pa; logic [TW-1:0] ts;
        do_reset(2'd1, 32'd2);
        miss_vld = 4'b0111;
        miss_pc[0*PCW +: PCW] = 64'hA0;
        miss_pc[1*PCW +: PCW] = 64'hA1;
        miss_pc[2*PCW +: PCW] = 64'hA2;
        tick();
        miss_vld = '0;
        n_cmp++; if (last_pc !== 64'hA0) begin n_fail++; $display("FAIL mp_lastpc: got %h exp a0", last_pc); end
        miss(2, 64'hB2, 56'h0);
        miss(3, 64'hC3, 56'h0);
        n_cmp++; if (occupancy !== 3'd2) begin n_fail++; $display("FAIL mp_occ: got %0d exp 2", occupancy); end
        pop(v, p, pc, pa, ts);
        n_cmp++; if (p !== 2'd0 || pc !== 64'hA0) begin n_fail++; $display("FAIL mp_first: got port %0d pc %h exp port 0 pc a0", p, pc); end
        pop(v, p, pc, pa, ts);
        n_cmp++; if (p !== 2'd2 || pc !== 64'hB2) begin n_fail++; $display("FAIL mp_second: got port %0d pc %h exp port 2 pc b2", p, pc); end
    endtask

    task automatic test_filters();
        logic v; logic [1:0] p; logic [PCW-1:0] pc; logic [AW-1:0] pa; logic [TW-1:0] ts;
        filt_base = 64'h8000_1000;
        filt_mask = 64'hFFFF_F000;
        do_reset(2'd2, 32'd1);
        miss(3, 64'h1, 56'h8000_1040);
        miss(3, 64'h2, 56'h8000_2000);
        n_cmp++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL addr_occ: got %0d exp 1", occupancy); end
        n_cmp++; if (miss_cnt[3*CW +: CW] !== 32'd2) begin n_fail++; $display("FAIL addr_misscnt3: got %0d exp 2", miss_cnt[3*CW +: CW]); end
        pop(v, p, pc, pa, ts);
        n_cmp++; if (p !== 2'd3 || pa !== 56'h8000_1040) begin n_fail++; $display("FAIL addr_head: got port %0d paddr %h exp port 3 paddr 80001040", p, pa); end
        mode = 2'd3;
        miss(0, 64'h8000_1111, 56'h5);
        miss(0, 64'h8000_1222, 56'h6);
        miss(1, 64'h7000_0000, 56'h7);
        n_cmp++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL pc_occ: got %0d exp 1", occupancy); end
        pop(v, p, pc, pa, ts);
        n_cmp++; if (p !== 2'd0 || pc !== 64'h8000_1222) begin n_fail++; $display("FAIL pc_head: got port %0d pc %h exp port 0 pc 80001222", p, pc); end
        mode = 2'd0;
        tick();
        miss(0, 64'h8000_1333, 56'h8);
        miss(0, 64'h8000_1444, 56'h9);
        n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL off_occ: got %0d exp 0", occupancy); end
        n_cmp++; if (miss_cnt[0*CW +: CW] !== 32'd4) begin n_fail++; $display("FAIL off_misscnt0: got %0d exp 4", miss_cnt[0*CW +: CW]); end
        enable = 1'b0;
        miss(0, 64'h55, 56'h0);
        n_cmp++; if (miss_cnt[0*CW +: CW] !== 32'd4) begin n_fail++; $display("FAIL dis_misscnt0: got %0d exp 4", miss_cnt[0*CW +: CW]); end
        n_cmp++; if (last_pc !== 64'h8000_1444) begin n_fail++; $display("FAIL dis_lastpc: got %h exp 80001444", last_pc); end
        enable = 1'b1;
    endtask

    task automatic test_fifo_full();
        logic v; logic [1:0] p; logic [PCW-1:0] pc; logic [AW-1:0] pa; logic [TW-1:0] ts;
        int exp_occ; int exp_drop;
        do_reset(2'd1, 32'd1);
        for (int i = 0; i < 6; i++) begin
            miss(0, 64'h100 + 64'(i), 56'h0);
            exp_occ = (i + 1 > 4) ? 4 : i + 1;
            exp_drop = (i > 3) ? i - 3 : 0;
            n_cmp++; if (occupancy !== 3'(exp_occ)) begin n_fail++; $display("FAIL full_occ%0d: got %0d exp %0d", i, occupancy, exp_occ); end
            n_cmp++; if (drop_cnt !== 32'(exp_drop)) begin n_fail++; $display("FAIL full_drop%0d: got %0d exp %0d", i, drop_cnt, exp_drop); end
            n_cmp++; if (irq !== (exp_occ >= 4)) begin n_fail++; $display("FAIL full_irq%0d: got %b exp %b", i, irq, exp_occ >= 4); end
        end
        smpl_if.ready = 1'b1;
        miss(0, 64'h200, 56'h0);
        smpl_if.ready = 1'b0;
        n_cmp++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL pp_occ: got %0d exp 4", occupancy); end
        n_cmp++; if (drop_cnt !== 32'd2) begin n_fail++; $display("FAIL pp_drop: got %0d exp 2", drop_cnt); end
        for (int k = 0; k < 4; k++) begin
            pop(v, p, pc, pa, ts);
            n_cmp++; if (pc !== ((k == 3) ? 64'h200 : 64'h101 + 64'(k))) begin n_fail++; $display("FAIL pp_pc%0d: got %h exp %h", k, pc, (k == 3) ? 64'h200 : 64'h101 + 64'(k)); end
        end
        n_cmp++; if (occupancy !== 3'd0 || smpl_if.valid !== 1'b0) begin n_fail++; $display("FAIL pp_empty: got occ %0d valid %b exp 0 0", occupancy, smpl_if.valid); end
    endtask

    task automatic test_clear();
        do_reset(2'd1, 32'd2);
        for (int i = 0; i < 5; i++) begin
            miss(2, 64'h300 + 64'(i), 56'h0);
        end
        n_cmp++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL clr_pre_occ: got %0d exp 3", occupancy); end
        n_cmp++; if (miss_cnt[2*CW +: CW] !== 32'd5) begin n_fail++; $display("FAIL clr_pre_misscnt2: got %0d exp 5", miss_cnt[2*CW +: CW]); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL clr_occ: got %0d exp 0", occupancy); end
        n_cmp++; if (miss_cnt !== '0) begin n_fail++; $display("FAIL clr_misscnt: got %h exp 0", miss_cnt); end
        n_cmp++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL clr_drop: got %0d exp 0", drop_cnt); end
        n_cmp++; if (smpl_if.valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b exp 0", smpl_if.valid); end
        miss(2, 64'h400, 56'h0);
        n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL clr_reload1: got %0d exp 0", occupancy); end
        miss(2, 64'h401, 56'h0);
        n_cmp++; if (occupancy !== 3'd1 || smpl_if.pc !== 64'h401) begin n_fail++; $display("FAIL clr_reload2: got occ %0d pc %h exp 1 401", occupancy, smpl_if.pc); end
    endtask

    task automatic test_async_reset();
        do_reset(2'd1, 32'd3);
        for (int i = 0; i < 4; i++) begin
            miss(1, 64'h500 + 64'(i), 56'h0);
        end
        n_cmp++; if (occupancy !== 3'd2) begin n_fail++; $display("FAIL ar_pre_occ: got %0d exp 2", occupancy); end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++; if (occupancy !== 3'd0 || smpl_if.valid !== 1'b0) begin n_fail++; $display("FAIL ar_fifo: got occ %0d valid %b exp 0 0", occupancy, smpl_if.valid); end
        n_cmp++; if (miss_cnt !== '0 || last_pc !== '0) begin n_fail++; $display("FAIL ar_cnt: got misscnt %h lastpc %h exp 0 0", miss_cnt, last_pc); end
        n_cmp++; if (smpl_if.pc !== '0 || drop_cnt !== '0 || irq !== 1'b0) begin n_fail++; $display("FAIL ar_out: got pc %h drop %0d irq %b exp 0", smpl_if.pc, drop_cnt, irq); end
        tick();
        rst = 1'b0;
        miss(1, 64'h600, 56'h0);
        n_cmp++; if (occupancy !== 3'd1 || smpl_if.pc !== 64'h600) begin n_fail++; $display("FAIL ar_first: got occ %0d pc %h exp 1 600", occupancy, smpl_if.pc); end
    endtask

    initial begin
        smpl_if.ready = 1'b0;
        test_reset();
        test_period();
        test_multi_port();
        test_filters();
        test_fifo_full();
        test_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within 200000 ns");
        $fatal(1);
    end
endmodule
